// File: rtl/vector_operand_loader.sv
// Vector operand loader: fetches VECTOR_LENGTH words per operand, then issues a packed bundle.
// Optional macro VECTOR_LOADER_STRIDE_EN adds a signed byte-stride input (default: unit stride of 4 bytes).
module vector_operand_loader #(
   parameter int VECTOR_LENGTH = 8,
   parameter int DATA_WIDTH    = 32,
   parameter int ADDR_WIDTH    = 32
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                start,
   input  logic [ADDR_WIDTH-1:0]               base_a,
   input  logic [ADDR_WIDTH-1:0]               base_b,
   input  logic [DATA_WIDTH-1:0]               scalar_in,
   input  logic [1:0]                          mode_in,
   input  logic [2:0]                          funct3_in,
`ifdef VECTOR_LOADER_STRIDE_EN
   input  logic signed [ADDR_WIDTH-1:0]        stride,
`endif
   output logic                                mem_req,
   output logic [ADDR_WIDTH-1:0]               mem_addr,
   input  logic                                mem_ack,
   input  logic [DATA_WIDTH-1:0]               mem_rdata,
   output logic [VECTOR_LENGTH*DATA_WIDTH-1:0] vector_a,
   output logic [VECTOR_LENGTH*DATA_WIDTH-1:0] vector_b,
   output logic [DATA_WIDTH-1:0]               scalar,
   output logic [1:0]                          mode,
   output logic [2:0]                          funct3,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic                                busy
);

   localparam int CNT_W = (VECTOR_LENGTH > 1) ? $clog2(VECTOR_LENGTH) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(VECTOR_LENGTH - 1);

   typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, ISSUE} state_t;

   state_t                        state, state_nxt;
   logic [CNT_W-1:0]              cnt_q;
   logic [ADDR_WIDTH-1:0]         addr_q;
   logic [ADDR_WIDTH-1:0]         base_b_q;
   logic signed [ADDR_WIDTH-1:0]  stride_q;
   logic                          elem_ack;
   logic                          last_ack;

   // Modular address step; a negative stride simply wraps downward.
   function automatic logic [ADDR_WIDTH-1:0] step_addr(input logic [ADDR_WIDTH-1:0]        addr,
                                                        input logic signed [ADDR_WIDTH-1:0] step);
      return addr + step;
   endfunction

`ifndef VECTOR_LOADER_STRIDE_EN
   assign stride_q = $signed(ADDR_WIDTH'(4));
`endif

   assign mem_req   = (state == LOAD_A) || (state == LOAD_B);
   assign mem_addr  = mem_req ? addr_q : '0;
   assign out_valid = (state == ISSUE);
   assign busy      = (state != IDLE);
   assign elem_ack  = mem_req && mem_ack;
   assign last_ack  = elem_ack && (cnt_q == LAST);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start)     state_nxt = LOAD_A;
         LOAD_A:  if (last_ack)  state_nxt = (mode == 2'b00) ? LOAD_B : ISSUE;
         LOAD_B:  if (last_ack)  state_nxt = ISSUE;
         ISSUE:   if (out_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   // Operand capture and element sequencing.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         addr_q   <= '0;
         base_b_q <= '0;
         vector_a <= '0;
         vector_b <= '0;
         scalar   <= '0;
         mode     <= '0;
         funct3   <= '0;
`ifdef VECTOR_LOADER_STRIDE_EN
         stride_q <= '0;
`endif
      end else if (state == IDLE) begin
         if (start) begin
            addr_q   <= base_a;
            base_b_q <= base_b;
            scalar   <= scalar_in;
            mode     <= mode_in;
            funct3   <= funct3_in;
            vector_b <= '0;
            cnt_q    <= '0;
`ifdef VECTOR_LOADER_STRIDE_EN
            stride_q <= stride;
`endif
         end
      end else if (elem_ack) begin
         if (state == LOAD_A) vector_a[int'(cnt_q)*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata;
         else                 vector_b[int'(cnt_q)*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata;
         // At the end of A the address register is preloaded for a possible B pass.
         if (cnt_q == LAST) begin
            cnt_q  <= '0;
            addr_q <= base_b_q;
         end else begin
            cnt_q  <= cnt_q + 1'b1;
            addr_q <= step_addr(addr_q, stride_q);
         end
      end
   end

endmodule

// File: tb/tb_vector_operand_loader.sv
// Directed bench for vector_operand_loader; memory word at byte address X reads as X/4.
`timescale 1ns/1ps
module tb_vector_operand_loader;
   localparam int VL = 8;
   localparam int DW = 32;
   localparam int AW = 32;
`ifdef VECTOR_LOADER_STRIDE_EN
   localparam int NV = 7;
`else
   localparam int NV = 6;
`endif

   logic           clk = 1'b0;
   logic           rst, start, mem_req, mem_ack, out_valid, out_ready, busy;
   logic [AW-1:0]  base_a, base_b, mem_addr;
   logic [DW-1:0]  scalar_in, mem_rdata, scalar;
   logic [1:0]     mode_in, mode;
   logic [2:0]     funct3_in, funct3;
   logic [VL*DW-1:0] vector_a, vector_b;
`ifdef VECTOR_LOADER_STRIDE_EN
   logic [AW-1:0]  stride;
`endif

   always #5 clk = ~clk;

   vector_operand_loader #(.VECTOR_LENGTH(VL), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .base_a(base_a), .base_b(base_b),
      .scalar_in(scalar_in), .mode_in(mode_in), .funct3_in(funct3_in),
`ifdef VECTOR_LOADER_STRIDE_EN
      .stride(stride),
`endif
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .vector_a(vector_a), .vector_b(vector_b), .scalar(scalar), .mode(mode), .funct3(funct3),
      .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
   );

   typedef struct {
      logic [1:0]  mode;
      logic [31:0] base_a, base_b, scalar, stride;
      logic [2:0]  f3;
      int          period, exp_lat, exp_reads;
      logic [31:0] a0, b0, inc;
   } vec_t;

   vec_t tv[NV];
   int   n_checks = 0;
   int   n_fail = 0;

   // Memory responder: acks every ack_period-th requesting cycle, logs accepted addresses.
   int            ack_period = 1;
   bit            stray_ack = 1'b0;
   int            wait_cnt = 0;
   int            n_acks = 0;
   int            stab_err = 0;
   logic          prev_pend = 1'b0;
   logic [AW-1:0] prev_addr = '0;
   logic [AW-1:0] q_addr[$];

   always @(negedge clk) begin
      if (mem_req && prev_pend && mem_addr !== prev_addr) stab_err++;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      if (mem_req) begin
         if (wait_cnt >= ack_period - 1) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_addr >> 2;
            wait_cnt  = 0;
            q_addr.push_back(mem_addr);
            n_acks++;
         end else begin
            wait_cnt++;
         end
      end else begin
         wait_cnt = 0;
         if (stray_ack) begin
            mem_ack   = 1'b1;
            mem_rdata = 32'hDEAD_BEEF;
         end
      end
      prev_pend = mem_req && !mem_ack;
      prev_addr = mem_addr;
   end

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [VL*DW-1:0] build_vec(input logic [31:0] first, input logic [31:0] inc);
      logic [VL*DW-1:0] v;
      for (int i = 0; i < VL; i++) v[i*DW +: DW] = (first + i*inc) & 32'h3FFF_FFFF;
      return v;
   endfunction

   // Drives one start pulse and returns the cycle distance from accept to out_valid.
   task automatic launch(input vec_t t, output int lat);
      ack_period = t.period;
      @(negedge clk);
      base_a = t.base_a; base_b = t.base_b; scalar_in = t.scalar;
      mode_in = t.mode; funct3_in = t.f3;
`ifdef VECTOR_LOADER_STRIDE_EN
      stride = t.stride;
`endif
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      while (!out_valid && lat < 300) begin
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      vec_t t;
      int   lat, qb, sb, ab, guard;
      logic [31:0] ea;
      logic [VL*DW-1:0] exp_a;

      tv[0] = '{2'b00, 32'h100, 32'h200, 32'h11, 32'h4, 3'b000, 1, 17, 16, 32'h40, 32'h80, 32'h1};
      tv[1] = '{2'b01, 32'h0, 32'h300, 32'h5, 32'h4, 3'b010, 1, 9, 8, 32'h0, 32'h0, 32'h1};
      tv[2] = '{2'b01, 32'h40, 32'h0, 32'h9, 32'h4, 3'b001, 3, 25, 8, 32'h10, 32'h0, 32'h1};
      tv[3] = '{2'b01, 32'hFFFF_FFF8, 32'h0, 32'h0, 32'h4, 3'b011, 1, 9, 8, 32'h3FFF_FFFE, 32'h0, 32'h1};
      tv[4] = '{2'b10, 32'h1000, 32'h0, 32'h1F, 32'h4, 3'b100, 1, 9, 8, 32'h400, 32'h0, 32'h1};
      tv[5] = '{2'b11, 32'h80, 32'h900, 32'h3, 32'h4, 3'b110, 1, 9, 8, 32'h20, 32'h0, 32'h1};
`ifdef VECTOR_LOADER_STRIDE_EN
      tv[6] = '{2'b01, 32'h20, 32'h0, 32'h0, 32'hFFFF_FFFC, 3'b000, 1, 9, 8, 32'h8, 32'h0, 32'hFFFF_FFFF};
      stride = 32'h4;
`endif

      rst = 1'b1; start = 1'b0; out_ready = 1'b0;
      base_a = '0; base_b = '0; scalar_in = '0; mode_in = '0; funct3_in = '0;
      repeat (2) @(negedge clk);
      check("reset_mem_req", mem_req, 0);
      check("reset_mem_addr", mem_addr, 0);
      check("reset_out_valid", out_valid, 0);
      check("reset_busy", busy, 0);
      check("reset_vector_a", vector_a, 0);
      rst = 1'b0;

      // Reset after three acks in LOAD_A aborts the load.
      ab = n_acks;
      t = tv[1];
      @(negedge clk);
      base_a = 32'h0; mode_in = 2'b01; scalar_in = 32'h42; funct3_in = 3'b111; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      guard = 0;
      while (n_acks - ab < 3 && guard < 50) begin
         @(posedge clk);
         guard++;
      end
      check("abort_reached_3_acks", guard < 50, 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_mem_req", mem_req, 0);
      check("abort_busy", busy, 0);
      check("abort_vector_a", vector_a, 0);
      check("abort_out_valid", out_valid, 0);
      check("abort_scalar", scalar, 0);

      for (int k = 0; k < NV; k++) begin
         t  = tv[k];
         qb = q_addr.size();
         sb = stab_err;
         launch(t, lat);
         check($sformatf("v%0d_latency", k), lat, t.exp_lat);
         check($sformatf("v%0d_reads", k), q_addr.size() - qb, t.exp_reads);
         for (int i = 0; i < t.exp_reads && qb + i < q_addr.size(); i++) begin
            ea = (i < VL) ? t.base_a + i*t.stride : t.base_b + (i-VL)*t.stride;
            check($sformatf("v%0d_addr%0d", k, i), q_addr[qb+i], ea);
         end
         check($sformatf("v%0d_addr_stable", k), stab_err - sb, 0);
         check($sformatf("v%0d_vector_a", k), vector_a, build_vec(t.a0, t.inc));
         check($sformatf("v%0d_vector_b", k), vector_b,
               (t.mode == 2'b00) ? build_vec(t.b0, t.inc) : '0);
         check($sformatf("v%0d_scalar", k), scalar, t.scalar);
         check($sformatf("v%0d_mode", k), mode, t.mode);
         check($sformatf("v%0d_funct3", k), funct3, t.f3);
         check($sformatf("v%0d_issue_req", k), mem_req, 0);
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
         check($sformatf("v%0d_done_valid", k), out_valid, 0);
         check($sformatf("v%0d_done_busy", k), busy, 0);
      end

      // Backpressure: bundle held, stray acks and start pulses ignored.
      t = '{2'b01, 32'h500, 32'h0, 32'h77, 32'h4, 3'b101, 1, 9, 8, 32'h140, 32'h0, 32'h1};
      exp_a = build_vec(t.a0, t.inc);
      launch(t, lat);
      check("bp_latency", lat, 9);
      stray_ack = 1'b1;
      for (int c = 0; c < 10; c++) begin
         start  = (c == 4);
         base_a = 32'h7000;
         @(negedge clk);
         check($sformatf("bp_valid_c%0d", c), out_valid, 1);
         check($sformatf("bp_vector_a_c%0d", c), vector_a, exp_a);
         check($sformatf("bp_scalar_c%0d", c), scalar, 32'h77);
      end
      out_ready = 1'b1;
      start = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      start = 1'b0;
      check("bp_done_valid", out_valid, 0);
      check("bp_done_busy", busy, 0);
      check("bp_done_mem_req", mem_req, 0);
      @(negedge clk);
      check("bp_idle_busy", busy, 0);
      check("bp_retain_vector_a", vector_a, exp_a);
      check("bp_retain_funct3", funct3, 3'b101);
      check("bp_retain_mode", mode, 2'b01);
      stray_ack = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/vector_operand_loader.md
Name: vector_operand_loader

Overview:
- Upstream feeder for the vector execute stage (packed-vector add/sub/mul/and/or unit).
- Fetches VECTOR_LENGTH words per operand from a word-addressed memory read port, one element at a time.
- Assembles the words into packed vector_a/vector_b buses and latches scalar/mode/funct3.
- Presents one complete operand bundle to the execute stage with a valid/ready handshake.

Parameters:
- VECTOR_LENGTH, 8, elements per vector.
- DATA_WIDTH, 32, bits per element and per memory word.
- ADDR_WIDTH, 32, byte-address width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  launch request; accepted only in IDLE.
- base_a  input  ADDR_WIDTH  byte address of element 0 of vector A.
- base_b  input  ADDR_WIDTH  byte address of element 0 of vector B (used only when mode=00).
- scalar_in  input  DATA_WIDTH  scalar/immediate operand.
- mode_in  input  2  00 VV, 01 VX, 10 VI, 11 reserved (treated as VX).
- funct3_in  input  3  operation selector, passed through.
- mem_req  output  1  read request.
- mem_addr  output  ADDR_WIDTH  read byte address.
- mem_ack  input  1  read complete; mem_rdata valid in the same cycle.
- mem_rdata  input  DATA_WIDTH  read data.
- vector_a  output  VECTOR_LENGTH*DATA_WIDTH  packed operand A; element i at [i*DATA_WIDTH +: DATA_WIDTH].
- vector_b  output  VECTOR_LENGTH*DATA_WIDTH  packed operand B; all zeros when mode is not VV.
- scalar  output  DATA_WIDTH  latched scalar.
- mode  output  2  latched mode.
- funct3  output  3  latched funct3.
- out_valid  output  1  operand bundle valid.
- out_ready  input  1  execute stage accepts the bundle.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, active-high) drives:
  - state IDLE; mem_req=0; mem_addr=0; out_valid=0; busy=0.
  - vector_a=0, vector_b=0, scalar=0, mode=0, funct3=0; element counter=0.
- FSM states: IDLE, LOAD_A, LOAD_B, ISSUE.
- IDLE:
  - On start=1, latch base_a, base_b, scalar_in, mode_in, funct3_in.
  - Clear vector_b to 0 and the counter to 0.
  - Go to LOAD_A; mem_req=1 and mem_addr=base_a from the next cycle.
- LOAD_A:
  - mem_req held high and mem_addr stable until mem_ack.
  - On mem_ack, write mem_rdata into element [counter] of vector_a and increment counter.
  - mem_addr = base_a + 4*counter, computed modulo 2^ADDR_WIDTH; wrap-around is allowed and not flagged.
  - After element VECTOR_LENGTH-1 is acked, reset counter to 0.
  - Then go to LOAD_B if mode=00, otherwise to ISSUE; mem_req drops in ISSUE.
- LOAD_B: identical to LOAD_A, using base_b and vector_b; then go to ISSUE.
- Back-to-back acks on consecutive cycles are legal, giving one element per cycle.
  - Minimum latency from start accept to out_valid: VECTOR_LENGTH+1 cycles for VX/VI, 2*VECTOR_LENGTH+1 for VV.
- ISSUE:
  - out_valid=1; all output buses held stable while out_valid=1 and out_ready=0.
  - The handshake completes on the cycle out_valid & out_ready; go to IDLE with out_valid=0 next cycle.
  - vector_a, vector_b, scalar, mode and funct3 retain their values in IDLE.
- start while busy is ignored; there is no queuing.
- start in the same cycle as the ISSUE handshake is also ignored, because the FSM is not yet in IDLE.
- mem_ack while mem_req=0 is ignored.
- The counter never exceeds VECTOR_LENGTH-1.
- rst asserted mid-load or during ISSUE aborts immediately to the reset state.
  - The partial vector is discarded; mem_req drops the cycle after rst is sampled.
- Inputs other than start, mem_ack, mem_rdata and out_ready are sampled only at start accept.

Optional Feature:
- Macro: VECTOR_LOADER_STRIDE_EN.
- When defined:
  - Adds input stride, ADDR_WIDTH wide, a signed byte stride latched at start.
  - Element address = base + counter*stride, computed modulo 2^ADDR_WIDTH.
  - stride=0 reads the same word VECTOR_LENGTH times, a broadcast load.
- When undefined:
  - The stride port does not exist; the stride is fixed at +4 (unit-stride).

Test Plan:
- VV load, memory word at byte address X = X/4, base_a=0x100, base_b=0x200, mem_ack every cycle.
  - Response: vector_a elements 0x40..0x47 and vector_b elements 0x80..0x87.
  - out_valid rises exactly 17 cycles after start accept.
- VX load, mode=01, scalar_in=5, funct3=010, base_a=0x0.
  - Response: exactly 8 requests, no LOAD_B; vector_b=0, scalar=5, funct3=010.
  - out_valid 9 cycles after accept.
- Memory stalls: mem_ack every 3rd cycle in VX mode.
  - Response: mem_addr stable while awaiting ack; element order correct; 8 accepted reads only.
- Backpressure: out_ready=0 for 10 cycles in ISSUE; start pulsed during ISSUE.
  - Response: out_valid and buses stable; start ignored; IDLE one cycle after out_ready=1.
- rst asserted after 3 acks in LOAD_A.
  - Response: next cycle mem_req=0, busy=0, vector_a=0, out_valid=0.
  - A new start then performs a full 8-element load.
- Address wrap: base_a=0xFFFF_FFF8, mode=01.
  - Response: addresses FFFF_FFF8, FFFF_FFFC, 0, 4, 8, C, 10, 14.
- With VECTOR_LOADER_STRIDE_EN: stride=0xFFFF_FFFC (-4), base_a=0x20.
  - Response: addresses 0x20 down to 0x04.
